tmr: RTL and testbench

//  Bus responder (slave) for the CPU bus: a memory-mapped interval timer plus a millisecond counter.
//  - Answers the CPU's word-addressed stb/we/ack handshake on a 4-word window.
//  - Raises a level interrupt toward one bus_irq line when the interval expires.
//  - Sits in the I/O address decode beside the other devices; the decoder qualifies stb.

---
 rtl/tmr_pkg.sv | 32 +++
 rtl/tmr_presc.sv | 28 ++
 rtl/tmr.sv | 154 +++++++++++++++
 tb/tb_tmr.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tmr_pkg.sv
// Shared definitions for the interval timer: register map, CTRL bit layout,
// bus FSM state type and a helper that packs the CTRL read word.
package tmr_pkg;

  // Word offsets inside the 4-word register window
  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_DIV  = 2'd1;
  localparam logic [1:0] ADDR_CNT  = 2'd2;
  localparam logic [1:0] ADDR_MS   = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_EXP = 31;

  // Bus responder states: IDLE waits for stb, ACK is the single ack cycle
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Pack CTRL for reads; unused bits read as zero
  function automatic logic [31:0] ctrl_word(input logic en, input logic ie, input logic exp_flag);
    logic [31:0] w;
    w           = '0;
    w[CTRL_EN]  = en;
    w[CTRL_IE]  = ie;
    w[CTRL_EXP] = exp_flag;
    return w;
  endfunction

endpackage

// File: rtl/tmr_presc.sv
// Prescaler: counts 0..PRESC-1 and flags the wrap cycle with a one-cycle tick.
module tmr_presc #(
  parameter int PRESC = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [W-1:0] LAST = W'(PRESC - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Tick is high during the last count; the count wraps to 0 on that edge
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + W'(1);
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tmr.sv
// Memory-mapped interval timer with a free-running millisecond counter.
// Bus handshake: an access starts when stb=1 is seen while the responder is
// idle (ack=0). On that edge the write commits and the read data is captured;
// ack is then high for exactly one cycle and data_out is valid only while
// ack=1 (zero otherwise). The cycle after ack the responder is idle again, so
// a stb held high is treated as a fresh access acknowledged one cycle later.
module tmr
  import tmr_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int TICK_HZ  = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stb,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        irq
);

  localparam int PRESC = CLK_FREQ / TICK_HZ;

  // Bus FSM
  bus_state_e state_q;
  bus_state_e state_d;
  logic       access;
  logic       wr;

  // Register file and timer state
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        exp_q, exp_d;
  logic [31:0] div_q, div_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] ms_q, ms_d;
  logic [31:0] data_out_q, data_out_d;
  logic        irq_q, irq_d;
  logic        exp_set;
  logic        tick;

  tmr_presc #(.PRESC(PRESC)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Bus FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= BUS_IDLE;
    else      state_q <= state_d;
  end

  // Bus FSM next state: IDLE -> ACK on stb, ACK -> IDLE unconditionally
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUS_IDLE: if (stb) state_d = BUS_ACK;
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  // Bus FSM outputs: an access is accepted only from IDLE
  always_comb begin
    access = (state_q == BUS_IDLE) && stb;
    wr     = access && we;
    ack    = (state_q == BUS_ACK);
  end

  // Read mux samples the pre-update register values at the acking edge
  always_comb begin
    data_out_d = '0;
    if (access && !we) begin
      unique case (addr)
        ADDR_CTRL: data_out_d = ctrl_word(en_q, ie_q, exp_q);
        ADDR_DIV:  data_out_d = div_q;
        ADDR_CNT:  data_out_d = cnt_q;
        ADDR_MS:   data_out_d = ms_q;
        default:   data_out_d = '0;
      endcase
    end
  end

  // Timer, ms counter and register writes; expiry beats a concurrent EXP clear
  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    exp_d   = exp_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    ms_d    = ms_q + {31'd0, tick};
    exp_set = 1'b0;

    if (en_q) begin
      if (cnt_q > 32'd1) begin
        cnt_d = cnt_q - 32'd1;
      end else begin
        cnt_d   = div_q;
        exp_set = (cnt_q == 32'd1);
      end
    end

    if (wr) begin
      unique case (addr)
        ADDR_CTRL: begin
          en_d = data_in[CTRL_EN];
          ie_d = data_in[CTRL_IE];
          if (data_in[CTRL_EXP]) exp_d = 1'b0;
        end
        ADDR_DIV: begin
          div_d = data_in;
          if (en_q) cnt_d = data_in;
        end
        ADDR_MS:  ms_d = data_in;
        ADDR_CNT: ;
        default:  ;
      endcase
    end

    if (exp_set) exp_d = 1'b1;

    irq_d = exp_q & ie_q;
  end

  // Register state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      exp_q      <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      ms_q       <= '0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      exp_q      <= exp_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ms_q       <= ms_d;
      data_out_q <= data_out_d;
      irq_q      <= irq_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_tmr.sv
// Directed bench for tmr with a small prescaler (PRESC=10).
module tb_tmr;
  import tmr_pkg::*;

  localparam int CLK_FREQ = 10;
  localparam int TICK_HZ  = 1;
  localparam int PRESC    = CLK_FREQ / TICK_HZ;

  logic        clk;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        irq;

  int n_checks;
  int n_fail;

  // Scoreboard of expected read data
  logic [31:0] exp_q[$];

  // Edge count since reset release and the last ms write reference point
  int unsigned cyc;
  int unsigned last_cyc;
  logic [31:0] ms_base;
  int unsigned ms_base_cyc;

  tmr #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) dut (
    .clk      (clk),
    .rst      (rst),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .ack      (ack),
    .irq      (irq)
  );

  // Clock and reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus access; reads push the expected data and pop it at ack
  task automatic bus_xfer(input logic w, input logic [1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input string tag);
    bit got;
    logic [31:0] e;
    if (ack === 1'b1) tick_n(1);
    if (!w) exp_q.push_back(exp_rd);
    stb = 1'b1; we = w; addr = a; data_in = wd;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      got = (ack === 1'b1);
    end
    if (!got) begin
      check({tag, "_ack_timeout"}, {31'd0, ack}, 32'd1);
      if (!w) e = exp_q.pop_front();
    end else if (!w) begin
      e = exp_q.pop_front();
      check(tag, data_out, e);
    end
    last_cyc = cyc;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    bus_xfer(1'b1, a, wd, 32'd0, "write");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] expv, input string tag);
    bus_xfer(1'b0, a, 32'd0, expv, tag);
  endtask

  // MS model: reference value plus ticks on edges after the reference edge
  task automatic read_ms(input string tag);
    logic [31:0] expv;
    if (ack === 1'b1) tick_n(1);
    expv = ms_base + 32'((cyc / PRESC) - (ms_base_cyc / PRESC));
    rd(ADDR_MS, expv, tag);
  endtask

  task automatic write_ms(input logic [31:0] v);
    wr(ADDR_MS, v);
    ms_base     = v;
    ms_base_cyc = last_cyc;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; data_in = '0;
    ms_base = '0; ms_base_cyc = 0;

    // Reset state
    tick_n(3);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    rst = 1'b1;

    // 1: first access acked one cycle later, for one cycle
    stb = 1'b1; we = 1'b0; addr = ADDR_CTRL;
    check("t1_ack_before", {31'd0, ack}, 32'd0);
    tick_n(1);
    check("t1_ack_high", {31'd0, ack}, 32'd1);
    check("t1_ctrl_rd", data_out, 32'd0);
    stb = 1'b0;
    tick_n(1);
    check("t1_ack_low", {31'd0, ack}, 32'd0);
    check("t1_data_out_low", data_out, 32'd0);
    rd(ADDR_DIV, 32'd0, "t1_div_rst");
    rd(ADDR_CNT, 32'd0, "t1_cnt_rst");

    // 2: DIV=5 periodic expiry, irq, clear
    wr(ADDR_DIV, 32'd5);
    wr(ADDR_CTRL, 32'd3);
    tick_n(6);
    check("t2_irq_before", {31'd0, irq}, 32'd0);
    tick_n(1);
    check("t2_irq_rise", {31'd0, irq}, 32'd1);
    rd(ADDR_CNT, 32'd4, "t2_cnt_a");
    rd(ADDR_CNT, 32'd2, "t2_cnt_b");
    rd(ADDR_CNT, 32'd5, "t2_cnt_reload");
    wr(ADDR_CTRL, 32'h8000_0003);
    check("t2_irq_hold", {31'd0, irq}, 32'd1);
    tick_n(1);
    check("t2_irq_drop", {31'd0, irq}, 32'd0);
    rd(ADDR_CTRL, 32'h0000_0003, "t2_ctrl_cleared");
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_CTRL, 32'h8000_0000);
    rd(ADDR_CTRL, 32'd0, "t2_ctrl_off");

    // 3: DIV=1 expires every cycle; clears lose against the set
    wr(ADDR_DIV, 32'd1);
    wr(ADDR_CTRL, 32'd3);
    tick_n(10);
    for (int i = 0; i < 3; i++) wr(ADDR_CTRL, 32'h8000_0003);
    rd(ADDR_CTRL, 32'h8000_0003, "t3_set_wins");
    check("t3_irq", {31'd0, irq}, 32'd1);
    wr(ADDR_CTRL, 32'd0);
    wr(ADDR_CTRL, 32'h8000_0000);
    rd(ADDR_CTRL, 32'd0, "t3_ctrl_off");
    rd(ADDR_CNT, 32'd1, "t3_cnt_frozen");
    check("t3_irq_off", {31'd0, irq}, 32'd0);

    // 5: stb held high over three writes
    tick_n(1);
    stb = 1'b1; we = 1'b1; addr = ADDR_DIV; data_in = 32'h0000_000A;
    check("t5_ack_0", {31'd0, ack}, 32'd0);
    tick_n(1);
    check("t5_ack_1", {31'd0, ack}, 32'd1);
    addr = ADDR_CTRL; data_in = 32'h0000_0002;
    tick_n(1);
    check("t5_ack_2", {31'd0, ack}, 32'd0);
    tick_n(1);
    check("t5_ack_3", {31'd0, ack}, 32'd1);
    addr = ADDR_MS; data_in = 32'h0000_1234;
    tick_n(1);
    check("t5_ack_4", {31'd0, ack}, 32'd0);
    tick_n(1);
    check("t5_ack_5", {31'd0, ack}, 32'd1);
    ms_base = 32'h0000_1234; ms_base_cyc = cyc;
    stb = 1'b0; we = 1'b0;
    rd(ADDR_DIV, 32'h0000_000A, "t5_div");
    rd(ADDR_CTRL, 32'h0000_0002, "t5_ctrl");
    read_ms("t5_ms");
    rd(ADDR_CNT, 32'd1, "t5_cnt_untouched");

    // 6: reset during the ack cycle of a DIV=7 write
    wr(ADDR_DIV, 32'd3);
    wr(ADDR_CTRL, 32'd3);
    tick_n(12);
    check("t6_irq_pre", {31'd0, irq}, 32'd1);
    stb = 1'b1; we = 1'b1; addr = ADDR_DIV; data_in = 32'd7;
    tick_n(1);
    check("t6_ack_pre", {31'd0, ack}, 32'd1);
    rst = 1'b0;
    #1;
    check("t6_ack_rst", {31'd0, ack}, 32'd0);
    check("t6_irq_rst", {31'd0, irq}, 32'd0);
    check("t6_data_out_rst", data_out, 32'd0);
    stb = 1'b0; we = 1'b0;
    tick_n(2);
    rst = 1'b1;
    ms_base = '0; ms_base_cyc = 0;
    rd(ADDR_DIV, 32'd0, "t6_div_rst");
    rd(ADDR_CTRL, 32'd0, "t6_ctrl_rst");

    // 4: ms counter after 100 clocks, then wrap
    for (int i = 0; i < 200 && cyc < 100; i++) tick_n(1);
    check("t4_reached_100", cyc, 32'd100);
    read_ms("t4_ms_100");
    write_ms(32'hFFFF_FFFF);
    tick_n(10);
    read_ms("t4_ms_wrap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
